// File: rtl/types_pkg.sv
// Shared types for the strategy controller: variant codes, controller states, helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package types_pkg;

  localparam int VARIANT_NUM = 5;

  typedef enum logic [2:0] {
    SELF_TEST   = 3'd0,
    EXPERIMENT  = 3'd1,
    CALIBRATION = 3'd2,
    PRODUCTION  = 3'd3,
    DIAGNOSTIC  = 3'd4
  } variants_t;

  typedef enum logic [1:0] {
    ACTIVE,
    DRAIN,
    GUARD,
    RELEASE
  } strategy_state_t;

  // A raw 3-bit request code is usable only if it names one of the variants.
  function automatic logic is_legal_variant(input logic [2:0] code);
    return code < 3'(VARIANT_NUM);
  endfunction

  // Active-low reset vector that releases only the given variant's FSM.
  function automatic logic [VARIANT_NUM-1:0] variant_onehot(input variants_t v);
    return VARIANT_NUM'(1) << v;
  endfunction

endpackage

// File: rtl/strategy_cnt.sv
// Loadable down-counter with a zero flag, shared by the controller's timed states.
// Latency: load/decrement visible one cycle after the request; zero flag is combinational from the count.
// Backpressure: none; saturates at zero instead of wrapping.
module strategy_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins over decrement; stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/strategy_ctrl.sv
// Strategy switch controller: drains the running FSM, holds all FSMs in reset, then releases the new one.
// Latency: all outputs registered; a switch takes >=1 DRAIN + GUARD_CYCLES + 1 RELEASE cycles.
// Backpressure: req_ready only in ACTIVE; requests elsewhere are ignored. Optional macro: STRATEGY_TIMEOUT_EN.
module strategy_ctrl
  import types_pkg::*;
#(
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [2:0]             req_variant,
  output logic                   req_ready,
  input  logic                   fsm_idle,
  output variants_t              strategy_sel,
  output logic [VARIANT_NUM-1:0] fsm_rst_n,
  output logic                   out_gate,
  output logic                   switch_done,
  output logic                   err_invalid,
  output logic                   err_timeout
);

  // One counter serves both waits, so it is sized for the longer of the two.
  localparam int MAX_WAIT = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  // GUARD always starts unarmed (this is also the reset condition), spends its
  // first cycle loading the counter, and leaves when the armed counter hits zero.
  localparam logic [CNT_W-1:0] GUARD_LOAD =
    CNT_W'((GUARD_CYCLES >= 2) ? (GUARD_CYCLES - 2) : 0);

  strategy_state_t        state_q, state_d;
  variants_t              sel_q, sel_d;
  variants_t              pend_q, pend_d;
  logic [VARIANT_NUM-1:0] rst_q, rst_d;
  logic                   gate_q, gate_d;
  logic                   done_q, done_d;
  logic                   inv_q, inv_d;
  logic                   armed_q, armed_d;
  logic                   enter_guard;
  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_load_val;
  logic                   cnt_dec;
  logic                   cnt_zero;

`ifdef STRATEGY_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  logic                   to_q, to_d;
`endif

  strategy_cnt #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state and registered-output logic for the switch sequence.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pend_d       = pend_q;
    rst_d        = rst_q;
    gate_d       = gate_q;
    armed_d      = armed_q;
    done_d       = 1'b0;
    inv_d        = 1'b0;
    enter_guard  = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
`ifdef STRATEGY_TIMEOUT_EN
    to_d         = 1'b0;
`endif

    case (state_q)
      ACTIVE: begin
        if (req_valid) begin
          if (!is_legal_variant(req_variant)) begin
            inv_d = 1'b1;
          end else if (req_variant == sel_q) begin
            // Already running: acknowledge without disturbing anything.
            done_d = 1'b1;
          end else begin
            pend_d  = variants_t'(req_variant);
            state_d = DRAIN;
`ifdef STRATEGY_TIMEOUT_EN
            cnt_load     = 1'b1;
            cnt_load_val = TIMEOUT_LOAD;
`endif
          end
        end
      end

      DRAIN: begin
        // Idle wins over a simultaneous timeout expiry.
        if (fsm_idle) begin
          enter_guard = 1'b1;
`ifdef STRATEGY_TIMEOUT_EN
        end else if (cnt_zero) begin
          to_d        = 1'b1;
          enter_guard = 1'b1;
        end else begin
          cnt_dec = 1'b1;
`endif
        end
      end

      GUARD: begin
        if (!armed_q) begin
          if (GUARD_CYCLES == 1) begin
            state_d = RELEASE;
            rst_d   = variant_onehot(sel_q);
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = GUARD_LOAD;
            armed_d      = 1'b1;
          end
        end else if (cnt_zero) begin
          state_d = RELEASE;
          rst_d   = variant_onehot(sel_q);
          armed_d = 1'b0;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      RELEASE: begin
        state_d = ACTIVE;
        gate_d  = 1'b1;
        done_d  = 1'b1;
      end

      default: begin
        state_d = GUARD;
      end
    endcase

    // Switch over to the new variant with every FSM held in reset and outputs gated.
    if (enter_guard) begin
      state_d = GUARD;
      sel_d   = pend_q;
      rst_d   = '0;
      gate_d  = 1'b0;
      armed_d = 1'b0;
    end
  end

  // State and output registers; reset restarts the boot sequence into SELF_TEST.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= GUARD;
      sel_q   <= SELF_TEST;
      pend_q  <= SELF_TEST;
      rst_q   <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      inv_q   <= inv_d;
      armed_q <= armed_d;
    end
  end

`ifdef STRATEGY_TIMEOUT_EN
  // Timeout pulse register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_q <= 1'b0;
    end else begin
      to_q <= to_d;
    end
  end

  assign err_timeout = to_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign req_ready    = (state_q == ACTIVE);
  assign strategy_sel = sel_q;
  assign fsm_rst_n    = rst_q;
  assign out_gate     = gate_q;
  assign switch_done  = done_q;
  assign err_invalid  = inv_q;

endmodule

// File: tb/tb_strategy_ctrl.sv
// Bench for strategy_ctrl: directed sequences with literal expectations plus a random run
// checked every cycle against a schedule-based model of the switch sequence.
`timescale 1ns/1ps
module tb_strategy_ctrl;
  import types_pkg::*;

  localparam int G = 4;
`ifdef STRATEGY_TIMEOUT_EN
  localparam int T     = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int T     = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_variant = 3'd0;
  logic       req_ready;
  logic       fsm_idle = 1'b0;
  variants_t  strategy_sel;
  logic [4:0] fsm_rst_n;
  logic       out_gate;
  logic       switch_done;
  logic       err_invalid;
  logic       err_timeout;

  always #5 clock = ~clock;

  strategy_ctrl #(
    .GUARD_CYCLES   (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_variant  (req_variant),
    .req_ready    (req_ready),
    .fsm_idle     (fsm_idle),
    .strategy_sel (strategy_sel),
    .fsm_rst_n    (fsm_rst_n),
    .out_gate     (out_gate),
    .switch_done  (switch_done),
    .err_invalid  (err_invalid),
    .err_timeout  (err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: sw_age counts cycles since the switch (guard) began, -1 when running.
  int m_sel, m_pend, sw_age, drain_n;
  bit draining, e_done, e_inv, e_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sel    = 0;
    m_pend   = 0;
    sw_age   = 0;
    draining = 1'b0;
    drain_n  = 0;
    e_done   = 1'b0;
    e_inv    = 1'b0;
    e_to     = 1'b0;
  endtask

  task automatic model_update(input bit v, input int code, input bit idle);
    e_done = 1'b0;
    e_inv  = 1'b0;
    e_to   = 1'b0;
    if (sw_age >= 0) begin
      sw_age++;
      if (sw_age == G + 1) begin
        sw_age = -1;
        e_done = 1'b1;
      end
    end else if (draining) begin
      drain_n++;
      if (idle || (TO_EN && drain_n == T)) begin
        e_to     = !idle;
        draining = 1'b0;
        sw_age   = 0;
        m_sel    = m_pend;
      end
    end else if (v) begin
      if (code > 4) e_inv = 1'b1;
      else if (code == m_sel) e_done = 1'b1;
      else begin
        draining = 1'b1;
        drain_n  = 0;
        m_pend   = code;
      end
    end
  endtask

  task automatic compare_all();
    logic [4:0] e_rst;
    e_rst = (sw_age >= 0 && sw_age < G) ? 5'd0 : (5'd1 << m_sel);
    chk("strategy_sel", 32'(strategy_sel), 32'(m_sel));
    chk("fsm_rst_n", 32'(fsm_rst_n), 32'(e_rst));
    chk("out_gate", 32'(out_gate), 32'(sw_age < 0));
    chk("req_ready", 32'(req_ready), 32'(!draining && sw_age < 0));
    chk("switch_done", 32'(switch_done), 32'(e_done));
    chk("err_invalid", 32'(err_invalid), 32'(e_inv));
    chk("err_timeout", 32'(err_timeout), 32'(e_to));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input int code, input bit idle);
    compare_all();
    req_valid   = v;
    req_variant = 3'(code);
    fsm_idle    = idle;
    @(posedge clock);
    model_update(v, code, idle);
    @(negedge clock);
  endtask

  initial begin
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_sel", 32'(strategy_sel), 32'd0);
    chk("reset_rst_n", 32'(fsm_rst_n), 32'h00);
    chk("reset_gate", 32'(out_gate), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    compare_all();

    // Boot: GUARD x4, RELEASE, ACTIVE on cycle 6.
    reset = 1'b1;
    repeat (G) step(1'b0, 0, 1'b0);
    chk("boot_release_rst_n", 32'(fsm_rst_n), 32'h01);
    chk("boot_release_gate", 32'(out_gate), 32'd0);
    step(1'b0, 0, 1'b0);
    chk("boot_active_gate", 32'(out_gate), 32'd1);
    chk("boot_done", 32'(switch_done), 32'd1);
    chk("boot_active_sel", 32'(strategy_sel), 32'd0);

    // SELF_TEST -> EXPERIMENT with immediate idle.
    step(1'b1, 1, 1'b1);
    chk("drain_ready", 32'(req_ready), 32'd0);
    chk("drain_rst_n", 32'(fsm_rst_n), 32'h01);
    step(1'b0, 0, 1'b1);
    chk("guard_sel", 32'(strategy_sel), 32'd1);
    chk("guard_rst_n", 32'(fsm_rst_n), 32'h00);
    repeat (G - 1) step(1'b0, 0, 1'b0);
    chk("guard_end_rst_n", 32'(fsm_rst_n), 32'h00);
    step(1'b0, 0, 1'b0);
    chk("release_rst_n", 32'(fsm_rst_n), 32'h02);
    chk("release_gate", 32'(out_gate), 32'd0);
    step(1'b0, 0, 1'b0);
    chk("switch_done_exp", 32'(switch_done), 32'd1);

    // Illegal code.
    step(1'b1, 6, 1'b0);
    chk("invalid_pulse", 32'(err_invalid), 32'd1);
    chk("invalid_sel", 32'(strategy_sel), 32'd1);
    chk("invalid_ready", 32'(req_ready), 32'd1);
    step(1'b0, 0, 1'b0);
    chk("invalid_one_cycle", 32'(err_invalid), 32'd0);

    // Same-variant request.
    step(1'b1, 1, 1'b0);
    chk("same_done", 32'(switch_done), 32'd1);
    chk("same_gate", 32'(out_gate), 32'd1);

    // Reset mid-GUARD while switching to CALIBRATION.
    step(1'b1, 2, 1'b1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("mid_guard_sel", 32'(strategy_sel), 32'd2);
    #3 reset = 1'b0;
    #1;
    chk("async_sel", 32'(strategy_sel), 32'd0);
    chk("async_rst_n", 32'(fsm_rst_n), 32'h00);
    chk("async_pulses", 32'({switch_done, err_invalid, err_timeout}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (G + 1) step(1'b0, 0, 1'b0);
    chk("restart_done", 32'(switch_done), 32'd1);
    chk("restart_rst_n", 32'(fsm_rst_n), 32'h01);

`ifdef STRATEGY_TIMEOUT_EN
    // Drain timeout with fsm_idle held low.
    step(1'b1, 3, 1'b0);
    repeat (T - 1) step(1'b0, 0, 1'b0);
    chk("timeout_not_yet", 32'(err_timeout), 32'd0);
    step(1'b0, 0, 1'b0);
    chk("timeout_pulse", 32'(err_timeout), 32'd1);
    chk("timeout_sel", 32'(strategy_sel), 32'd3);
    repeat (G + 1) step(1'b0, 0, 1'b0);
    chk("timeout_switch_done", 32'(switch_done), 32'd1);
`endif

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 15));
    end
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/strategy_ctrl.md
STRATEGY_CTRL -- requirements
Module: strategy_ctrl

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 4, number of cycles all strategy FSMs are held in reset between strategies (legal 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum drain wait for the active FSM to report idle (legal 2..65535).
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  host strategy-change request valid.
REQ-006 SHALL have port req_variant  input  3  requested strategy code, raw (may be out of range).
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port fsm_idle  input  1  the currently selected strategy FSM is in its idle state.
REQ-009 SHALL have port strategy_sel  output  variants_t  select driven to the strategy output multiplexer.
REQ-010 SHALL have port fsm_rst_n  output  5  per-strategy FSM reset, active-low, indexed by variants_t value.
REQ-011 SHALL have port out_gate  output  1  high = multiplexer output passed; low = downstream forces outputs to '0.
REQ-012 SHALL have port switch_done  output  1  one-cycle pulse: requested strategy now running.
REQ-013 SHALL have port err_invalid  output  1  one-cycle pulse: request code not a legal variants_t value.
REQ-014 SHALL have port err_timeout  output  1  one-cycle pulse: drain wait expired, switch forced.

Function
REQ-015 SHALL implement states ACTIVE, DRAIN, GUARD, RELEASE; req_ready SHALL be 1 only in ACTIVE.
REQ-016 Request SHALL be accepted on a rising edge with req_valid && req_ready; req_variant captured that edge.
REQ-017 Accepted code > 4 SHALL pulse err_invalid next cycle, remain ACTIVE, leave all other outputs unchanged.
REQ-018 Accepted code equal to current strategy_sel SHALL pulse switch_done next cycle, remain ACTIVE, no reset or gating.
REQ-019 Any other legal accepted code SHALL enter DRAIN next cycle; strategy_sel, fsm_rst_n, out_gate unchanged in DRAIN.
REQ-020 In DRAIN, fsm_idle=1 sampled on an edge SHALL move to GUARD on that edge (earliest: 1 DRAIN cycle).
REQ-021 On GUARD entry strategy_sel SHALL take the captured code, fsm_rst_n SHALL be 5'b00000, out_gate SHALL be 0.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles, then RELEASE for exactly 1 cycle with fsm_rst_n one-hot at strategy_sel, out_gate still 0.
REQ-023 After RELEASE, ACTIVE SHALL be entered with out_gate=1 and switch_done pulsed in the first ACTIVE cycle.
REQ-024 In ACTIVE, fsm_rst_n SHALL be one-hot at strategy_sel; unselected FSMs held in reset at all times.
REQ-025 req_valid outside ACTIVE SHALL be ignored (not queued); host holds request until req_ready.
REQ-026 Pulse outputs SHALL be high exactly one cycle per event; never two pulses in the same cycle.

Reset
REQ-027 Asserting reset SHALL asynchronously force: state GUARD, guard counter 0, strategy_sel=SELF_TEST, fsm_rst_n=5'b00000, out_gate=0, req_ready=0, all pulses 0.
REQ-028 After reset release the sequence SHALL be GUARD (GUARD_CYCLES) -> RELEASE -> ACTIVE with SELF_TEST running; switch_done SHALL pulse.
REQ-029 Reset asserted in DRAIN/GUARD/RELEASE SHALL discard the pending request; no error pulse.

Configuration
REQ-030 With STRATEGY_TIMEOUT_EN defined, a DRAIN count reaching TIMEOUT_CYCLES without fsm_idle SHALL pulse err_timeout and enter GUARD on the same edge; fsm_idle and expiry simultaneous SHALL count as idle (no err_timeout).
REQ-031 Without STRATEGY_TIMEOUT_EN, DRAIN SHALL wait indefinitely, no timeout counter SHALL exist, err_timeout SHALL be tied 0.

Structure
REQ-032 strategy_state_t enum and VARIANT_NUM (=5) constant SHALL live in types_pkg beside variants_t.
REQ-033 GUARD and DRAIN counting SHALL use one sub-module strategy_cnt (loadable down-counter with zero flag), instanced once and reloaded per state.

Verification
REQ-034 Reset release, GUARD_CYCLES=4 -> strategy_sel=SELF_TEST, fsm_rst_n=00001 and out_gate=1 on cycle 6, switch_done pulse there.
REQ-035 ACTIVE SELF_TEST, request 1 (EXPERIMENT), fsm_idle=1 -> DRAIN 1 cycle, GUARD 4 cycles at 00000, RELEASE at 00010, switch_done.
REQ-036 Request code 6 -> err_invalid one cycle, strategy_sel and fsm_rst_n unchanged, req_ready stays 1.
REQ-037 Request equal to current strategy -> switch_done next cycle, out_gate never drops.
REQ-038 With STRATEGY_TIMEOUT_EN, TIMEOUT_CYCLES=16, fsm_idle held 0 -> err_timeout after 16 DRAIN cycles, switch completes.
REQ-039 Reset asserted mid-GUARD while switching to CALIBRATION -> immediately SELF_TEST/00000, restart sequence, no error pulse.
